axis_rx_packet_sink: RTL

- AXI4-Stream receiver (slave) endpoint: terminates one stream, accepts beats and accumulates per-packet statistics.
- Checks per-packet TID/TDEST consistency and TKEEP legality.
- On the TLAST beat, emits one status record on a valid/ready status port.
- Sits opposite the bench's stream transmitter agent; the status port feeds scoreboard/CSR logic.

---
 rtl/axis_rx_packet_sink.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/axis_rx_packet_sink.sv
// AXI4-Stream receive endpoint: accepts packets, accumulates beat/byte counts,
// checks TID/TDEST/TKEEP per packet and emits one status record per TLAST.
// Optional first-beat TUSER capture is enabled by defining AXIS_RX_USER_CAPTURE_EN.
module axis_rx_packet_sink #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 16,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [KEEP_WIDTH-1:0] s_axis_tstrb,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  stat_valid,
  input  logic                  stat_ready,
  output logic [CNT_WIDTH-1:0]  stat_beats,
  output logic [CNT_WIDTH-1:0]  stat_bytes,
  output logic [ID_WIDTH-1:0]   stat_id,
  output logic [DEST_WIDTH-1:0] stat_dest,
  output logic [3:0]            stat_err,
`ifdef AXIS_RX_USER_CAPTURE_EN
  output logic [USER_WIDTH-1:0] stat_user,
`endif
  output logic                  stat_parity
);

  localparam int PC_WIDTH  = $clog2(KEEP_WIDTH + 1);
  localparam int SUM_WIDTH = ((CNT_WIDTH > PC_WIDTH) ? CNT_WIDTH : PC_WIDTH) + 1;
  localparam logic [SUM_WIDTH-1:0] CNT_MAX = SUM_WIDTH'({CNT_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic logic [PC_WIDTH-1:0] keep_popcount(input logic [KEEP_WIDTH-1:0] keep);
    logic [PC_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      n = n + PC_WIDTH'(keep[i]);
    end
    return n;
  endfunction

  function automatic logic lane_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic [KEEP_WIDTH-1:0] keep);
    logic p;
    p = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      p = p ^ (keep[i] & (^data[8*i +: 8]));
    end
    return p;
  endfunction

  // A mask is contiguous from bit 0 exactly when adding one clears every set bit.
  function automatic logic keep_contiguous(input logic [KEEP_WIDTH-1:0] keep);
    return (keep & (keep + KEEP_WIDTH'(1))) == '0;
  endfunction

  state_t                state;
  state_t                state_next;
  logic                  accept;
  logic                  first;
  logic [CNT_WIDTH-1:0]  beats_acc;
  logic [CNT_WIDTH-1:0]  bytes_acc;
  logic [3:0]            err_acc;
  logic                  parity_acc;
  logic [ID_WIDTH-1:0]   id_acc;
  logic [DEST_WIDTH-1:0] dest_acc;
  logic [SUM_WIDTH-1:0]  beats_sum;
  logic [SUM_WIDTH-1:0]  bytes_sum;
  logic                  count_sat;
  logic                  id_bad;
  logic                  dest_bad;
  logic                  keep_bad;
  logic [CNT_WIDTH-1:0]  beats_next;
  logic [CNT_WIDTH-1:0]  bytes_next;
  logic [3:0]            err_next;
  logic                  parity_next;
  logic [ID_WIDTH-1:0]   id_cur;
  logic [DEST_WIDTH-1:0] dest_cur;

`ifdef AXIS_RX_USER_CAPTURE_EN
  logic [USER_WIDTH-1:0] user_acc;
  logic [USER_WIDTH-1:0] user_cur;
`else
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;
`endif

  assign accept = s_axis_tvalid & s_axis_tready;
  assign first  = (state == IDLE);

  // Next-state decode; stat_ready outside HOLD has no effect.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, IN_PKT: begin
        if (accept && s_axis_tlast) begin
          state_next = HOLD;
        end else if (accept) begin
          state_next = IN_PKT;
        end else begin
          state_next = state;
        end
      end
      HOLD: begin
        if (stat_ready) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-beat accumulator update; the first beat starts from zero rather than stale state.
  always_comb begin
    beats_sum   = '0;
    bytes_sum   = '0;
    parity_next = 1'b0;
    err_next    = 4'b0000;
    id_cur      = id_acc;
    dest_cur    = dest_acc;
`ifdef AXIS_RX_USER_CAPTURE_EN
    user_cur    = user_acc;
`endif
    if (first) begin
      beats_sum   = SUM_WIDTH'(1);
      bytes_sum   = SUM_WIDTH'(keep_popcount(s_axis_tkeep));
      parity_next = lane_parity(s_axis_tdata, s_axis_tkeep);
      id_cur      = s_axis_tid;
      dest_cur    = s_axis_tdest;
`ifdef AXIS_RX_USER_CAPTURE_EN
      user_cur    = s_axis_tuser;
`endif
    end else begin
      beats_sum   = SUM_WIDTH'(beats_acc) + SUM_WIDTH'(1);
      bytes_sum   = SUM_WIDTH'(bytes_acc) + SUM_WIDTH'(keep_popcount(s_axis_tkeep));
      parity_next = parity_acc ^ lane_parity(s_axis_tdata, s_axis_tkeep);
      err_next    = err_acc;
    end

    id_bad   = !first && (s_axis_tid != id_acc);
    dest_bad = !first && (s_axis_tdest != dest_acc);
    if (s_axis_tlast) begin
      keep_bad = (|(s_axis_tstrb & ~s_axis_tkeep)) || !keep_contiguous(s_axis_tkeep);
    end else begin
      keep_bad = (|(s_axis_tstrb & ~s_axis_tkeep)) || (s_axis_tkeep != '1);
    end

    count_sat  = (beats_sum > CNT_MAX) || (bytes_sum > CNT_MAX);
    beats_next = (beats_sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : beats_sum[CNT_WIDTH-1:0];
    bytes_next = (bytes_sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : bytes_sum[CNT_WIDTH-1:0];
    err_next   = err_next | {count_sat, keep_bad, dest_bad, id_bad};
  end

  // State register with registered handshake outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      stat_valid    <= 1'b0;
    end else begin
      state         <= state_next;
      s_axis_tready <= (state_next != HOLD);
      stat_valid    <= (state_next == HOLD);
    end
  end

  // Packet accumulators, updated on every accepted beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      beats_acc  <= '0;
      bytes_acc  <= '0;
      err_acc    <= 4'b0000;
      parity_acc <= 1'b0;
      id_acc     <= '0;
      dest_acc   <= '0;
`ifdef AXIS_RX_USER_CAPTURE_EN
      user_acc   <= '0;
`endif
    end else if (accept) begin
      beats_acc  <= beats_next;
      bytes_acc  <= bytes_next;
      err_acc    <= err_next;
      parity_acc <= parity_next;
      id_acc     <= id_cur;
      dest_acc   <= dest_cur;
`ifdef AXIS_RX_USER_CAPTURE_EN
      user_acc   <= user_cur;
`endif
    end
  end

  // Status record, loaded from the TLAST beat and held stable through HOLD.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_beats  <= '0;
      stat_bytes  <= '0;
      stat_id     <= '0;
      stat_dest   <= '0;
      stat_err    <= 4'b0000;
      stat_parity <= 1'b0;
`ifdef AXIS_RX_USER_CAPTURE_EN
      stat_user   <= '0;
`endif
    end else if (accept && s_axis_tlast) begin
      stat_beats  <= beats_next;
      stat_bytes  <= bytes_next;
      stat_id     <= id_cur;
      stat_dest   <= dest_cur;
      stat_err    <= err_next;
      stat_parity <= parity_next;
`ifdef AXIS_RX_USER_CAPTURE_EN
      stat_user   <= user_cur;
`endif
    end
  end

endmodule
